// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: mode constants and FSM state encoding shared by the sweep checker
package gate_sweep_pkg;

    localparam logic [1:0] MODE_NAND = 2'd0;
    localparam logic [1:0] MODE_NOR  = 2'd1;
    localparam logic [1:0] MODE_AND  = 2'd2;
    localparam logic [1:0] MODE_OR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: golden N-input NAND/NOR/AND/OR selected by mode
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [1:0]   mode,
    input  logic [N-1:0] vec,
    output logic         y
);

    // reduce the vector according to the selected gate
    always_comb begin
        y = mode == MODE_NAND ? ~&vec :
            mode == MODE_NOR  ? ~|vec :
            mode == MODE_AND  ? &vec  : |vec;
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive truth-table sweep of an N-input gate against a reference function
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    output logic [N-1:0] stim,
    input  logic         dut_y,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail,
    output logic         first_fail_valid
);

    localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
    localparam logic [N-1:0] VLAST = '1;

    state_t        state, state_nx;
    logic [1:0]    mode_q;
    logic [N-1:0]  vec;
    logic [DW-1:0] dwell_cnt;
    logic          ref_y, accept, sample, last, miss;

    gate_ref_model #(.N(N)) u_ref (
        .mode (mode_q),
        .vec  (vec),
        .y    (ref_y)
    );

    // next state, status outputs and per-cycle sample/compare strobes
    always_comb begin
        busy     = state == RUN;
        done     = state == DONE;
        stim     = busy ? vec : '0;
        accept   = start && state != RUN;
        sample   = busy && dwell_cnt == DLAST;
        last     = sample && vec == VLAST;
        miss     = sample && dut_y != ref_y;
        state_nx = accept ? RUN : last ? DONE : state;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // sweep counters and result registers; vec wraps to 0 after the last sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q           <= '0;
            vec              <= '0;
            dwell_cnt        <= '0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else if (accept) begin
            mode_q           <= mode;
            vec              <= '0;
            dwell_cnt        <= '0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else if (busy) begin
            dwell_cnt <= sample ? '0 : dwell_cnt + 1'b1;
            if (sample) vec <= vec + 1'b1;
            if (miss) err_count <= err_count + 1'b1;
            if (miss && !first_fail_valid) begin
                first_fail       <= vec;
                first_fail_valid <= 1'b1;
            end
            if (last) pass <= err_count == '0 && !miss;
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed sweeps of NAND3/OR4 gates through the checker
module tb_gate_sweep_checker;
    import gate_sweep_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       start_a = 1'b0;
    logic [1:0] mode_a = MODE_NAND;
    logic [2:0] stim_a;
    logic       y_a, busy_a, done_a, pass_a, ffv_a;
    logic [3:0] err_a;
    logic [2:0] ff_a;
    logic       stuck = 1'b0;

    logic       start_b = 1'b0;
    logic [1:0] mode_b = MODE_OR;
    logic [3:0] stim_b;
    logic       y_b, busy_b, done_b, pass_b, ffv_b;
    logic [4:0] err_b;
    logic [3:0] ff_b;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign y_a = stuck ? 1'b1 : ~&stim_a;
    assign y_b = |stim_b;

    gate_sweep_checker #(.N(3), .DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .stim(stim_a),
        .dut_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail(ff_a), .first_fail_valid(ffv_a)
    );

    gate_sweep_checker #(.N(4), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .stim(stim_b),
        .dut_y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail(ff_b), .first_fail_valid(ffv_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input bit b, input logic [1:0] m, output int e0);
        @(negedge clk);
        if (b) begin start_b = 1'b1; mode_b = m; end
        else   begin start_a = 1'b1; mode_a = m; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input bit b, input int e0, input int dwell, output int lat);
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (b ? done_b : done_a) begin
                lat = cyc - e0;
                break;
            end
            check(b ? "stim_b" : "stim_a", b ? 32'(stim_b) : 32'(stim_a), (cyc - e0) / dwell);
            @(negedge clk);
        end
    endtask

    task automatic sweep(input bit b, input logic [1:0] m, output int lat);
        int e0;
        launch(b, m, e0);
        wait_done(b, e0, b ? 1 : 2, lat);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_stim"}, stim_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_pass"}, pass_a, 0);
        check({tag, "_err"}, err_a, 0);
        check({tag, "_ff"}, ff_a, 0);
        check({tag, "_ffv"}, ffv_a, 0);
    endtask

    initial begin
        int lat, e0;
        repeat (3) @(negedge clk);
        check_idle_a("rst");
        check("rst_err_b", err_b, 0);
        check("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy_a, 0);

        sweep(0, MODE_NAND, lat);
        check("ok_lat", lat, 16);
        check("ok_pass", pass_a, 1);
        check("ok_err", err_a, 0);
        check("ok_ffv", ffv_a, 0);
        check("ok_busy", busy_a, 0);
        check("ok_stim_done", stim_a, 0);

        stuck = 1'b1;
        sweep(0, MODE_NAND, lat);
        check("stuck_lat", lat, 16);
        check("stuck_err", err_a, 1);
        check("stuck_ff", ff_a, 3'b111);
        check("stuck_ffv", ffv_a, 1);
        check("stuck_pass", pass_a, 0);
        stuck = 1'b0;

        sweep(0, MODE_NOR, lat);
        check("nor_err", err_a, 6);
        check("nor_ff", ff_a, 3'b001);
        check("nor_pass", pass_a, 0);

        launch(0, MODE_NAND, e0);
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        mode_a = MODE_NOR;
        @(negedge clk);
        start_a = 1'b0;
        check("ign_busy", busy_a, 1);
        wait_done(0, e0, 2, lat);
        check("ign_lat", lat, 16);
        check("ign_pass", pass_a, 1);
        check("ign_err", err_a, 0);
        sweep(0, MODE_NOR, lat);
        check("b2b_lat", lat, 16);
        check("b2b_err", err_a, 6);
        check("b2b_ff", ff_a, 3'b001);

        launch(0, MODE_NOR, e0);
        for (int k = 0; k < 50 && stim_a != 3'd4; k++) @(negedge clk);
        check("mid_stim", stim_a, 4);
        check("mid_err", err_a, 3);
        check("mid_ffv", ffv_a, 1);
        #2 rst_n = 1'b0;
        #1 check_idle_a("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_busy", busy_a, 0);
        check("post_stim", stim_a, 0);
        sweep(0, MODE_NAND, lat);
        check("post_lat", lat, 16);
        check("post_pass", pass_a, 1);
        check("post_err", err_a, 0);

        sweep(1, MODE_OR, lat);
        check("or4_lat", lat, 16);
        check("or4_err", err_b, 0);
        check("or4_pass", pass_b, 1);
        sweep(1, MODE_NOR, lat);
        check("nor4_err", err_b, 5'd16);
        check("nor4_ff", ff_b, 0);
        check("nor4_pass", pass_b, 0);
        sweep(1, MODE_AND, lat);
        check("and4_err", err_b, 14);
        check("and4_ff", ff_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
